bpu_bht: RTL and testbench
==========================

# bpu_bht

- Branch prediction unit for the IF stage of the rv32imzicsr pipeline.
- Provides `branch_predict_pc` to the PC register every cycle from a direct-mapped branch target buffer with 2-bit saturating counters.
- Trained by the EX stage when conditional branches resolve.
- Lookup is combinational on `if_pc`; training is registered. The core consumes `predict_pc` as next-PC unless EX redirects.

## Interface
Parameters:
- ENTRIES, 16, number of BTB entries; power of two, 4..256; IDX = log2(ENTRIES)

Ports:
- clk  in  1  core clock; all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- if_pc  in  32  PC currently being fetched
- predict_taken  out  1  lookup hit with counter in a taken state
- predict_pc  out  32  predicted next fetch PC
- ex_upd_valid  in  1  EX resolved a conditional branch this cycle
- ex_upd_pc  in  32  PC of the resolved branch
- ex_upd_taken  in  1  actual branch outcome
- ex_upd_target  in  32  actual branch target (pc + imm)
- ex_upd_mispredict  in  1  EX redirect occurred for this branch; used only by the perf counters

## Operation
- Entry fields: valid (1), tag = pc[31:IDX+2], target = target[31:2], cnt (2).
- Index = pc[IDX+1:2]. pc[1:0] is ignored on lookup and update.
- Counter encoding:
  - 00 strongly not-taken; 01 weakly not-taken; 10 weakly taken; 11 strongly taken.
  - Saturates at 00 and 11; never wraps.
- Lookup:
  - hit = valid[idx] && tag[idx] == if_pc[31:IDX+2].
  - predict_taken = hit && cnt[idx][1].
  - predict_pc = predict_taken ? {target[idx], 2'b00} : if_pc + 4.
  - The add is 32-bit modulo: if_pc = 0xFFFF_FFFC yields 0x0000_0000.
- Update, when ex_upd_valid = 1:
  - Hit, taken: cnt increments (saturating); target is overwritten with ex_upd_target[31:2].
  - Hit, not-taken: cnt decrements (saturating); target is unchanged.
  - Miss, taken: allocate the entry. valid = 1, tag and target are written, cnt = 10. Any previous occupant is evicted.
  - Miss, not-taken: no state change; nothing is allocated.
- ex_upd_valid = 0: no state change regardless of the other ex_upd_* inputs.
- Lookup and update to the same index in the same cycle: the lookup uses pre-update state. There is no bypass.

## Timing
- Lookup latency: 0 cycles, combinational from if_pc and the registered state.
- Update latency: state changes at the rising edge where ex_upd_valid = 1 is sampled. It is visible to lookups from the following cycle.
- Reset:
  - Asynchronous and immediate.
  - All valid bits cleared, all cnt = 01, targets and tags cleared.
  - predict_taken = 0 and predict_pc = if_pc + 4 while rst_n = 0 and until the first allocation.
- Reset asserted mid-operation discards all training. A concurrent ex_upd_valid on the release edge is ignored only if rst_n is still low at that edge.
- No handshake:
  - EX asserts ex_upd_valid for exactly one cycle per resolved branch.
  - A flushed (squashed) branch must not assert it.

## Configuration
- BPU_PERF_EN defined: adds two outputs.
  - perf_branch_cnt (out, 32): increments on each ex_upd_valid.
  - perf_mispredict_cnt (out, 32): increments on each ex_upd_valid && ex_upd_mispredict.
  - Both reset to 0 and saturate at 0xFFFF_FFFF.
- BPU_PERF_EN undefined:
  - The ports do not exist and ex_upd_mispredict is unused.
  - Prediction behaviour is identical with and without the macro.

## Test plan
- Reset, if_pc = 0x0000_0010 -> predict_taken = 0, predict_pc = 0x0000_0014. With BPU_PERF_EN, both counters read 0.
- Allocate: update pc 0x10, taken, target 0x20. Next cycle if_pc = 0x10 -> predict_taken = 1, predict_pc = 0x20. if_pc = 0x50 (same index when ENTRIES = 16, different tag) -> predict_taken = 0, predict_pc = 0x54.
- Hysteresis:
  - From cnt = 10, one not-taken update -> 01; if_pc = 0x10 then predicts 0x14.
  - Three taken updates -> 11; two not-taken updates -> 01, not-taken.
  - Saturation: four further taken updates leave cnt at 11.
- Not-taken miss: update pc 0x30, not-taken -> entry stays invalid; if_pc = 0x30 predicts 0x34.
- Same-cycle collision: if_pc = 0x10 while updating pc 0x10 not-taken from cnt 10 -> that cycle predicts 0x20; the next cycle predicts 0x14.
- Edge cases:
  - if_pc = 0xFFFF_FFFC with no hit -> predict_pc = 0x0000_0000.
  - rst_n pulsed low mid-run -> all predictions revert to pc + 4.
  - With BPU_PERF_EN, 5 updates of which 2 are mispredicted -> perf_branch_cnt = 5, perf_mispredict_cnt = 2.

Source files
------------

// File: rtl/bpu_bht.sv
// Branch history table / BTB for IF-stage next-PC prediction: direct-mapped, 2-bit counters.
// Optional perf counters (branches, mispredicts) are built when BPU_PERF_EN is defined.
module bpu_bht #(
  parameter int unsigned ENTRIES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] if_pc,
  output logic        predict_taken,
  output logic [31:0] predict_pc,
  input  logic        ex_upd_valid,
  input  logic [31:0] ex_upd_pc,
  input  logic        ex_upd_taken,
  input  logic [31:0] ex_upd_target,
  input  logic        ex_upd_mispredict
`ifdef BPU_PERF_EN
  ,
  output logic [31:0] perf_branch_cnt,
  output logic [31:0] perf_mispredict_cnt
`endif
);

  localparam int unsigned IDX  = $clog2(ENTRIES);
  localparam int unsigned TAGW = 32 - IDX - 2;

  logic            valid_q [ENTRIES];
  logic [TAGW-1:0] tag_q   [ENTRIES];
  logic [29:0]     tgt_q   [ENTRIES];
  logic [1:0]      cnt_q   [ENTRIES];

  logic [IDX-1:0]  lk_idx;
  logic            lk_hit;
  logic [IDX-1:0]  up_idx;
  logic [TAGW-1:0] up_tag;
  logic            up_hit;
  logic [1:0]      cnt_d;

  always_comb begin
    lk_idx        = if_pc[IDX+1:2];
    lk_hit        = valid_q[lk_idx] && (tag_q[lk_idx] == if_pc[31:IDX+2]);
    predict_taken = lk_hit && cnt_q[lk_idx][1];
    predict_pc    = predict_taken ? {tgt_q[lk_idx], 2'b00} : if_pc + 32'd4;
  end

  always_comb begin
    up_idx = ex_upd_pc[IDX+1:2];
    up_tag = ex_upd_pc[31:IDX+2];
    up_hit = valid_q[up_idx] && (tag_q[up_idx] == up_tag);
    cnt_d  = cnt_q[up_idx];
    if (ex_upd_taken && (cnt_q[up_idx] != 2'b11)) begin
      cnt_d = cnt_q[up_idx] + 2'd1;
    end else if (!ex_upd_taken && (cnt_q[up_idx] != 2'b00)) begin
      cnt_d = cnt_q[up_idx] - 2'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
        tag_q[i]   <= '0;
        tgt_q[i]   <= '0;
        cnt_q[i]   <= 2'b01;
      end
    end else if (ex_upd_valid) begin
      if (up_hit) begin
        cnt_q[up_idx] <= cnt_d;
        if (ex_upd_taken) begin
          tgt_q[up_idx] <= ex_upd_target[31:2];
        end
      end else if (ex_upd_taken) begin
        // Taken miss allocates, evicting whatever aliased into this slot.
        valid_q[up_idx] <= 1'b1;
        tag_q[up_idx]   <= up_tag;
        tgt_q[up_idx]   <= ex_upd_target[31:2];
        cnt_q[up_idx]   <= 2'b10;
      end
    end
  end

`ifdef BPU_PERF_EN
  logic [31:0] perf_br_q, perf_br_d;
  logic [31:0] perf_mp_q, perf_mp_d;

  always_comb begin
    perf_br_d = perf_br_q;
    perf_mp_d = perf_mp_q;
    if (ex_upd_valid && (perf_br_q != '1)) begin
      perf_br_d = perf_br_q + 32'd1;
    end
    if (ex_upd_valid && ex_upd_mispredict && (perf_mp_q != '1)) begin
      perf_mp_d = perf_mp_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_br_q <= '0;
      perf_mp_q <= '0;
    end else begin
      perf_br_q <= perf_br_d;
      perf_mp_q <= perf_mp_d;
    end
  end

  assign perf_branch_cnt     = perf_br_q;
  assign perf_mispredict_cnt = perf_mp_q;

  logic [3:0] unused_bits;
  assign unused_bits = {ex_upd_pc[1:0], ex_upd_target[1:0]};
`else
  logic [4:0] unused_bits;
  assign unused_bits = {ex_upd_pc[1:0], ex_upd_target[1:0], ex_upd_mispredict};
`endif

endmodule

// File: tb/tb_bpu_bht.sv
// Directed self-checking bench for bpu_bht (ENTRIES = 16: index = pc[5:2], tag = pc[31:6]).
module tb_bpu_bht;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] if_pc;
  logic        predict_taken;
  logic [31:0] predict_pc;
  logic        ex_upd_valid;
  logic [31:0] ex_upd_pc;
  logic        ex_upd_taken;
  logic [31:0] ex_upd_target;
  logic        ex_upd_mispredict;
`ifdef BPU_PERF_EN
  logic [31:0] perf_branch_cnt;
  logic [31:0] perf_mispredict_cnt;
`endif

  int checks = 0;
  int errors = 0;

  bpu_bht #(.ENTRIES(16)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .if_pc             (if_pc),
    .predict_taken     (predict_taken),
    .predict_pc        (predict_pc),
    .ex_upd_valid      (ex_upd_valid),
    .ex_upd_pc         (ex_upd_pc),
    .ex_upd_taken      (ex_upd_taken),
    .ex_upd_target     (ex_upd_target),
    .ex_upd_mispredict (ex_upd_mispredict)
`ifdef BPU_PERF_EN
    ,
    .perf_branch_cnt     (perf_branch_cnt),
    .perf_mispredict_cnt (perf_mispredict_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Present a fetch PC and check both prediction outputs.
  task automatic look(input string tag, input logic [31:0] pc, input logic exp_t,
                      input logic [31:0] exp_pc);
    if_pc = pc;
    #1;
    chk({tag, "_taken"}, {31'd0, predict_taken}, {31'd0, exp_t});
    chk({tag, "_pc"}, predict_pc, exp_pc);
  endtask

  // One-cycle EX training pulse, launched mid-cycle.
  task automatic upd(input logic [31:0] pc, input logic tk, input logic [31:0] tgt,
                     input logic mp);
    @(negedge clk);
    ex_upd_valid      = 1'b1;
    ex_upd_pc         = pc;
    ex_upd_taken      = tk;
    ex_upd_target     = tgt;
    ex_upd_mispredict = mp;
    @(posedge clk);
    #1;
    ex_upd_valid      = 1'b0;
    ex_upd_mispredict = 1'b0;
  endtask

  initial begin
    rst_n             = 1'b0;
    if_pc             = 32'h10;
    ex_upd_valid      = 1'b0;
    ex_upd_pc         = '0;
    ex_upd_taken      = 1'b0;
    ex_upd_target     = '0;
    ex_upd_mispredict = 1'b0;

    #2;
    look("rst_active", 32'h10, 1'b0, 32'h14);
`ifdef BPU_PERF_EN
    chk("rst_perf_br", perf_branch_cnt, 32'd0);
    chk("rst_perf_mp", perf_mispredict_cnt, 32'd0);
`endif
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    look("post_rst", 32'h10, 1'b0, 32'h14);

    // Allocate, then alias check on the same index with a different tag.
    upd(32'h10, 1'b1, 32'h20, 1'b1);
    look("alloc_hit", 32'h10, 1'b1, 32'h20);
    look("alloc_lowbits", 32'h12, 1'b1, 32'h20);
    look("alias_miss", 32'h50, 1'b0, 32'h54);

    // Hysteresis: 10 -> 01 not-taken; taken x3 -> 11; not-taken x2 -> 01.
    upd(32'h10, 1'b0, 32'h0, 1'b1);
    look("cnt01", 32'h10, 1'b0, 32'h14);
    upd(32'h10, 1'b1, 32'h20, 1'b0);
    upd(32'h10, 1'b1, 32'h20, 1'b0);
    upd(32'h10, 1'b1, 32'h40, 1'b0);
    look("tgt_overwrite", 32'h10, 1'b1, 32'h40);
    upd(32'h10, 1'b0, 32'h0, 1'b0);
    look("cnt10_from11", 32'h10, 1'b1, 32'h40);
    upd(32'h10, 1'b0, 32'h0, 1'b0);
    look("cnt01_from10", 32'h10, 1'b0, 32'h14);

    // Saturation at 11: four taken then one not-taken must remain taken.
    for (int i = 0; i < 4; i++) upd(32'h10, 1'b1, 32'h20, 1'b0);
    look("sat11", 32'h10, 1'b1, 32'h20);
    upd(32'h10, 1'b0, 32'h0, 1'b0);
    look("sat11_dec", 32'h10, 1'b1, 32'h20);
    // Saturation at 00: down to 00, one extra not-taken, then one taken -> 01.
    for (int i = 0; i < 3; i++) upd(32'h10, 1'b0, 32'h0, 1'b0);
    upd(32'h10, 1'b1, 32'h20, 1'b0);
    look("sat00_inc", 32'h10, 1'b0, 32'h14);

    // Same-cycle collision: lookup sees pre-update state (cnt 10).
    upd(32'h10, 1'b1, 32'h20, 1'b0);
    @(negedge clk);
    ex_upd_valid  = 1'b1;
    ex_upd_pc     = 32'h10;
    ex_upd_taken  = 1'b0;
    ex_upd_target = 32'h0;
    look("collide_same", 32'h10, 1'b1, 32'h20);
    @(posedge clk);
    #1;
    ex_upd_valid = 1'b0;
    look("collide_next", 32'h10, 1'b0, 32'h14);

    // Not-taken miss allocates nothing.
    upd(32'h30, 1'b0, 32'h100, 1'b0);
    look("nt_miss", 32'h30, 1'b0, 32'h34);

    // Inputs without ex_upd_valid must be ignored.
    @(negedge clk);
    ex_upd_pc     = 32'h30;
    ex_upd_taken  = 1'b1;
    ex_upd_target = 32'h100;
    @(posedge clk);
    #1;
    look("valid_low", 32'h30, 1'b0, 32'h34);

    // Eviction of 0x10 by 0x50.
    upd(32'h50, 1'b1, 32'h80, 1'b0);
    look("evict_new", 32'h50, 1'b1, 32'h80);
    look("evict_old", 32'h10, 1'b0, 32'h14);

    look("pc_wrap", 32'hFFFF_FFFC, 1'b0, 32'h0000_0000);

    // Mid-run reset discards training.
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    look("midrst_active", 32'h50, 1'b0, 32'h54);
    @(negedge clk);
    rst_n = 1'b1;
    look("midrst_after", 32'h50, 1'b0, 32'h54);
    look("midrst_after30", 32'h30, 1'b0, 32'h34);

`ifdef BPU_PERF_EN
    upd(32'h10, 1'b1, 32'h20, 1'b1);
    upd(32'h10, 1'b0, 32'h0, 1'b0);
    upd(32'h30, 1'b0, 32'h0, 1'b1);
    upd(32'h10, 1'b1, 32'h20, 1'b0);
    upd(32'h50, 1'b1, 32'h80, 1'b0);
    chk("perf_br", perf_branch_cnt, 32'd5);
    chk("perf_mp", perf_mispredict_cnt, 32'd2);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
